serial_deframer: RTL and testbench
==================================

// Module: serial_deframer
// PURPOSE
//  Downstream consumer of the shift register's serial output (S_OUT). Hunts for a sync
//  pattern in the bit stream, assembles the next WIDTH bits into a parallel word and
//  hands it off on a VALID/READY port. Sits between the shift register and any word sink.
// PARAMETERS
//  WIDTH     4        data word width in bits (>=2)
//  SYNC_LEN  4        sync pattern length in bits (>=2)
//  SYNC      4'b1011  sync pattern, SYNC_LEN bits, compared MSB = oldest bit
// PORTS
//  CLK      in   1      clock, all state on posedge
//  RST_N    in   1      asynchronous reset, active low
//  ENB      in   1      bit strobe: S_IN is consumed only on edges with ENB=1
//  S_IN     in   1      serial data, driven by upstream S_OUT
//  DIR      in   1      bit order: 0 = MSB first, 1 = LSB first; latched at sync match
//  READY    in   1      sink accepts word when VALID&READY
//  Q        out  WIDTH  assembled word (holding register)
//  VALID    out  1      Q holds an unconsumed word
//  LOCKED   out  1      1 while in DATA or PAR state
//  OVERRUN  out  1      one-cycle pulse: completed word dropped, holding reg full
//  PAR_ERR  out  1      one-cycle pulse: parity mismatch, word dropped
// BEHAVIOUR
//  Reset (async, immediate): Q=0, VALID=0, LOCKED=0, OVERRUN=0, PAR_ERR=0, FSM=HUNT,
//   sync shifter=0, hunt count=0, bit count=0; any partial frame is discarded.
//  ENB=0: FSM, shifters, counters frozen; VALID/READY handshake still operates.
//  HUNT: each ENB edge shifts S_IN into sync shifter (newest at LSB), hunt count sat. at
//   SYNC_LEN. Match = count reaches SYNC_LEN (incl. current bit) and shifter == SYNC.
//   On match -> DATA, latch DIR, bit count=0. Overlapping patterns are detected.
//  DATA: each ENB edge shifts S_IN into word: DIR=0 {w[WIDTH-2:0],S_IN};
//   DIR=1 {S_IN,w[WIDTH-1:1]}. On bit WIDTH-1: -> PAR (macro on) or deliver + HUNT.
//  Deliver (same edge as last bit sampled, zero added latency): if VALID=0 or READY=1
//   in that cycle, Q<=word, VALID<=1; else word dropped, Q unchanged, OVERRUN pulses.
//  Handshake: VALID&READY with no delivery -> VALID<=0 next edge. Simultaneous consume
//   and deliver -> VALID stays 1, Q takes new word.
//  Return to HUNT always clears sync shifter and hunt count (no sync across data bits).
//  LOCKED = registered, 1 from edge after match to edge that ends frame.
// CONFIGURATION
//  `PARITY_CHECK_EN defined: frame = SYNC + WIDTH data + 1 even-parity bit. PAR state
//   consumes one ENB bit; XOR(word,bit)=0 -> deliver; else PAR_ERR pulses, word dropped,
//   VALID/Q unchanged. Both paths -> HUNT.
//  Not defined: no PAR state, delivery at last data bit, PAR_ERR tied to 0 (port kept).
// STRUCTURE
//  definitions.v: FSM state encodings (`DF_HUNT, `DF_DATA, `DF_PAR), bit-order codes
//   (`MSB_FIRST=0, `LSB_FIRST=1) shared with the shift register's DIR meaning.
//  One sub-module: sync_detect (sync shifter + hunt counter + match compare, params
//   SYNC_LEN/SYNC, inputs CLK,RST_N,ENB,S_IN,CLR; output MATCH). FSM, word shifter,
//   bit counter, holding register and parity in serial_deframer.
// TESTING  (WIDTH=4, SYNC_LEN=4, SYNC=1011, ENB=1 unless stated)
//  1 RST_N low mid-DATA -> all outputs 0 immediately; fresh 1011+0110 after release decodes.
//  2 DIR=0, READY=1, bits 1,0,1,1,0,1,1,0 -> Q=4'b0110, VALID high exactly one cycle,
//    LOCKED high 4 cycles.
//  3 DIR=1, bits 1,0,1,1,1,0,0,0 -> Q=4'b0001; leading junk 1,1,0,1,1 before sync ->
//    match on overlapping 1011, same Q.
//  4 READY=0, two frames (data 0110 then 1001) -> Q stays 0110, VALID=1, OVERRUN pulse
//    on second frame's last bit; READY=1 then -> VALID drops next edge.
//  5 ENB=0 for 3 cycles between data bits 2 and 3 (S_IN toggling) -> Q=4'b0110, no change.
//  6 `PARITY_CHECK_EN: 1011,0110,P=0 -> Q=0110 VALID; 1011,0110,P=1 -> PAR_ERR pulse,
//    VALID stays 0; without macro PAR_ERR constant 0.

Source files
------------

// File: rtl/serial_deframer_pkg.sv
// Shared definitions for the serial deframer: FSM state encodings and bit-order codes
// (bit-order meaning matches the upstream shift register's DIR input).
package serial_deframer_pkg;

    typedef enum logic [1:0] {
        DF_HUNT = 2'd0,
        DF_DATA = 2'd1,
        DF_PAR  = 2'd2
    } df_state_e;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_deframer_sync_detect.sv
// Sync hunter: shifts serial bits (newest at LSB) and flags a full-length match against SYNC,
// including the bit presented on the current edge. CLR wipes the history.
module sync_detect
    import serial_deframer_pkg::*;
#(
    parameter int                  SYNC_LEN = 4,
    parameter logic [SYNC_LEN-1:0] SYNC     = 4'b1011
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic ENB,
    input  logic S_IN,
    input  logic CLR,
    output logic MATCH
);

    localparam int            CW   = $clog2(SYNC_LEN + 1);
    localparam logic [CW-1:0] FULL = CW'(SYNC_LEN);

    logic [SYNC_LEN-1:0] sh_q, sh_d, sh_next;
    logic [CW-1:0]       cnt_q, cnt_d;

    always_comb begin
        sh_next = {sh_q[SYNC_LEN-2:0], S_IN};
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        if (CLR) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (ENB) begin
            sh_d = sh_next;
            if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
        end
    end

    // Count check keeps a zero-filled shifter from matching an all-zero pattern early.
    assign MATCH = ENB && (cnt_q >= FULL - 1'b1) && (sh_next == SYNC);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_deframer.sv
// Serial deframer: hunts for SYNC, assembles WIDTH bits into a word and offers it on VALID/READY.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per frame.
module serial_deframer
    import serial_deframer_pkg::*;
#(
    parameter int                  WIDTH    = 4,
    parameter int                  SYNC_LEN = 4,
    parameter logic [SYNC_LEN-1:0] SYNC     = 4'b1011
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENB,
    input  logic             S_IN,
    input  logic             DIR,
    input  logic             READY,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             LOCKED,
    output logic             OVERRUN,
    output logic             PAR_ERR
);

    localparam int            BW       = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    df_state_e        state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d, shifted, dlv_word;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             overrun_q, overrun_d;
    logic             deliver, clr, match, hunt_enb;

    // The hunter only sees bits while hunting, so it stays cleared across data bits.
    assign hunt_enb = ENB && (state_q == DF_HUNT);

    sync_detect #(
        .SYNC_LEN(SYNC_LEN),
        .SYNC    (SYNC)
    ) u_sync (
        .CLK  (CLK),
        .RST_N(RST_N),
        .ENB  (hunt_enb),
        .S_IN (S_IN),
        .CLR  (clr),
        .MATCH(match)
    );

`ifdef PARITY_CHECK_EN
    logic par_err_q, par_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        dir_d     = dir_q;
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        deliver   = 1'b0;
        dlv_word  = word_q;
        clr       = 1'b0;
`ifdef PARITY_CHECK_EN
        par_err_d = 1'b0;
`endif
        shifted = (dir_q == LSB_FIRST) ? {S_IN, word_q[WIDTH-1:1]}
                                       : {word_q[WIDTH-2:0], S_IN};
        case (state_q)
            DF_HUNT: begin
                if (match) begin
                    state_d   = DF_DATA;
                    dir_d     = DIR;
                    bit_cnt_d = '0;
                    clr       = 1'b1;
                end
            end
            DF_DATA: begin
                if (ENB) begin
                    word_d    = shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                        state_d  = DF_PAR;
`else
                        deliver  = 1'b1;
                        dlv_word = shifted;
                        state_d  = DF_HUNT;
`endif
                    end
                end
            end
            DF_PAR: begin
`ifdef PARITY_CHECK_EN
                if (ENB) begin
                    state_d = DF_HUNT;
                    if (^{word_q, S_IN}) par_err_d = 1'b1;
                    else                 deliver   = 1'b1;
                end
`else
                state_d = DF_HUNT;
`endif
            end
            default: state_d = DF_HUNT;
        endcase

        // A consume in the same cycle frees the holding register for the new word.
        if (deliver) begin
            if (!valid_q || READY) begin
                q_d     = dlv_word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        locked_d = (state_d != DF_HUNT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= DF_HUNT;
            word_q    <= '0;
            bit_cnt_q <= '0;
            dir_q     <= MSB_FIRST;
            q_q       <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_d;
            dir_q     <= dir_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) par_err_q <= 1'b0;
        else        par_err_q <= par_err_d;
    end
    assign PAR_ERR = par_err_q;
`else
    assign PAR_ERR = 1'b0;
`endif

    assign Q       = q_q;
    assign VALID   = valid_q;
    assign LOCKED  = locked_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_serial_deframer.sv
// Scoreboard bench for serial_deframer (WIDTH=4, SYNC=1011): stimulus pushes expected words,
// a negedge monitor pops and compares on every VALID&READY.
module tb_serial_deframer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       ENB = 1'b0;
    logic       S_IN = 1'b0;
    logic       DIR = 1'b0;
    logic       READY = 1'b0;
    logic [3:0] Q;
    logic       VALID, LOCKED, OVERRUN, PAR_ERR;

    serial_deframer #(.WIDTH(4), .SYNC_LEN(4), .SYNC(4'b1011)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENB(ENB), .S_IN(S_IN), .DIR(DIR), .READY(READY),
        .Q(Q), .VALID(VALID), .LOCKED(LOCKED), .OVERRUN(OVERRUN), .PAR_ERR(PAR_ERR)
    );

    always #5 CLK = ~CLK;

`ifdef PARITY_CHECK_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_q[$];
    int         valid_cyc = 0, locked_cyc = 0, ovr_cnt = 0, perr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            if (VALID)   valid_cyc++;
            if (LOCKED)  locked_cyc++;
            if (OVERRUN) ovr_cnt++;
            if (PAR_ERR) perr_cnt++;
            if (VALID && READY) begin
                if (exp_q.size() == 0) check("unexpected_word", {28'd0, Q}, 32'hFFFF);
                else                   check("word", {28'd0, Q}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            S_IN = bits[i];
            ENB  = 1'b1;
            @(posedge CLK); #1;
        end
        ENB = 1'b0;
    endtask

    // Sync + 4 data bits in arrival order, plus even parity when the build expects it.
    task automatic send_frame(input logic [3:0] data, input logic flip_par);
        logic [3:0] sy;
        sy = 4'b1011;
        send_bits({12'd0, sy}, 4);
        send_bits({12'd0, data}, 4);
        if (PBITS != 0) send_bits({15'd0, (^data) ^ flip_par}, 1);
    endtask

    task automatic idle(input int n);
        ENB = 1'b0;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    int v0, l0, o0;

    initial begin
        #12;
        check("rst_q", {28'd0, Q}, 0);
        check("rst_flags", {28'd0, VALID, LOCKED, OVERRUN, PAR_ERR}, 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Test 2: MSB first, READY high
        READY = 1'b1; DIR = 1'b0;
        v0 = valid_cyc; l0 = locked_cyc;
        exp_q.push_back(4'b0110);
        send_frame(4'b0110, 1'b0);
        idle(3);
        check("t2_valid_cycles", valid_cyc - v0, 1);
        check("t2_locked_cycles", locked_cyc - l0, 4 + PBITS);
        check("t2_valid_after", {31'd0, VALID}, 0);

        // Test 3: LSB first, then overlapping sync in junk
        DIR = 1'b1;
        exp_q.push_back(4'b0001);
        send_frame(4'b1000, 1'b0);
        idle(2);
        exp_q.push_back(4'b0001);
        send_bits(16'b11011, 5);
        send_bits(16'b1000, 4);
        if (PBITS != 0) send_bits(16'd1, 1);
        idle(2);
        DIR = 1'b0;

        // Test 4: back-pressure and overrun
        READY = 1'b0;
        o0 = ovr_cnt;
        send_frame(4'b0110, 1'b0);
        send_frame(4'b1001, 1'b0);
        check("t4_ovr_pulse", {31'd0, OVERRUN}, 1);
        idle(1);
        check("t4_ovr_count", ovr_cnt - o0, 1);
        check("t4_q_held", {28'd0, Q}, 4'b0110);
        check("t4_valid_held", {31'd0, VALID}, 1);
        exp_q.push_back(4'b0110);
        READY = 1'b1;
        idle(1);
        check("t4_valid_drop", {31'd0, VALID}, 0);

        // Test 5: ENB gaps between data bits 2 and 3
        exp_q.push_back(4'b0110);
        send_bits(16'b1011, 4);
        send_bits(16'b011, 3);
        for (int i = 0; i < 3; i++) begin
            S_IN = i[0]; ENB = 1'b0;
            @(posedge CLK); #1;
        end
        check("t5_locked_frozen", {31'd0, LOCKED}, 1);
        send_bits(16'b0, 1);
        if (PBITS != 0) send_bits(16'b0, 1);
        idle(2);

        // Test 1: reset in mid-frame with a word held
        READY = 1'b0;
        send_frame(4'b1100, 1'b0);
        send_bits(16'b101101, 6);
        #2 RST_N = 1'b0;
        #1;
        check("t1_async_q", {28'd0, Q}, 0);
        check("t1_async_flags", {28'd0, VALID, LOCKED, OVERRUN, PAR_ERR}, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1; READY = 1'b1;
        exp_q.push_back(4'b0110);
        send_frame(4'b0110, 1'b0);
        idle(2);

`ifdef PARITY_CHECK_EN
        // Test 6: bad parity drops the word
        v0 = valid_cyc;
        send_frame(4'b0110, 1'b1);
        check("t6_par_err", {31'd0, PAR_ERR}, 1);
        idle(2);
        check("t6_no_valid", valid_cyc - v0, 0);
        check("par_err_count", perr_cnt, 1);
`else
        check("par_err_count", perr_cnt, 0);
`endif
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
